// File: rtl/pipe_controller.sv
// pipe_controller: decode and E/M/W control pipeline for the 5-stage ARM-subset core.
// The D-stage decode is purely combinational. The E, M and W control registers
// and the retired-instruction counter all clear asynchronously while RESET is low.
module pipe_controller #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      INSTR,
    input  logic             FlagZ,
    input  logic             FlushE,
    output logic [1:0]       RegSrcD,
    output logic [1:0]       ImmSrcD,
    output logic             Sel14,
    output logic             ALUSrcE,
    output logic [3:0]       ALUControlE,
    output logic             FlagWriteE,
    output logic             BranchE,
    output logic             BranchTakenE,
    output logic             MemtoRegE,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             PCSrcD,
    output logic             PCSrcE,
    output logic             PCSrcM,
    output logic             PCSrcW,
    output logic             RegWriteW,
    output logic             MemtoRegW,
    output logic [CNT_W-1:0] RetiredW
);

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    // Decode outputs in D
    logic [1:0] op;
    logic       is_bx;
    logic       reg_write_d, mem_write_d, mem_to_reg_d, alu_src_d;
    logic       flag_write_d, branch_d, pcs_d, dp_d;
    logic [3:0] alu_ctrl_d;
    logic       unused_low_bits;

    // D->E registers
    logic       reg_write_e_q, mem_write_e_q, mem_to_reg_e_q, alu_src_e_q;
    logic       flag_write_e_q, branch_e_q, pcs_e_q, dp_e_q;
    logic [3:0] alu_ctrl_e_q, cond_e_q;

    // E->M and M->W registers
    logic       reg_write_m_q, mem_write_m_q, mem_to_reg_m_q, pcs_m_q, valid_m_q;
    logic       reg_write_w_q, mem_to_reg_w_q, pcs_w_q, valid_w_q;

    logic [CNT_W-1:0] retired_q, retired_d;
    logic             cond_ex_e, valid_e;

    assign op              = INSTR[27:26];
    assign is_bx           = (INSTR[27:4] == 24'h12FFF1);
    // The Rm field of BX is consumed by the datapath, not by control.
    assign unused_low_bits = ^INSTR[3:0];

    // Combinational decode of the D-stage instruction into control bits.
    always_comb begin
        reg_write_d  = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        alu_src_d    = 1'b0;
        flag_write_d = 1'b0;
        branch_d     = 1'b0;
        pcs_d        = 1'b0;
        dp_d         = 1'b0;
        alu_ctrl_d   = 4'b0000;
        RegSrcD      = 2'b00;
        ImmSrcD      = 2'b00;
        Sel14        = 1'b0;
        if (is_bx) begin
            // BX moves Rm into R15 through the ALU as a MOV.
            alu_ctrl_d = CMD_MOV;
            pcs_d      = 1'b1;
        end else begin
            case (op)
                2'b00: begin
                    dp_d         = 1'b1;
                    alu_ctrl_d   = INSTR[24:21];
                    alu_src_d    = INSTR[25];
                    reg_write_d  = (INSTR[24:21] != CMD_CMP);
                    flag_write_d = INSTR[20] | (INSTR[24:21] == CMD_CMP);
                end
                2'b01: begin
                    alu_ctrl_d = INSTR[23] ? CMD_ADD : CMD_SUB;
                    alu_src_d  = 1'b1;
                    ImmSrcD    = 2'b01;
                    if (INSTR[20]) begin
                        reg_write_d  = 1'b1;
                        mem_to_reg_d = 1'b1;
                    end else begin
                        mem_write_d = 1'b1;
                        RegSrcD     = 2'b10;
                    end
                end
                2'b10: begin
                    branch_d    = 1'b1;
                    alu_ctrl_d  = CMD_ADD;
                    alu_src_d   = 1'b1;
                    ImmSrcD     = 2'b10;
                    RegSrcD     = 2'b01;
                    Sel14       = INSTR[24];
                    reg_write_d = INSTR[24];
                end
                default: ;
            endcase
        end
    end

    assign PCSrcD = pcs_d;

    // D->E register; a flush inserts an all-zero bubble.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            reg_write_e_q  <= 1'b0;
            mem_write_e_q  <= 1'b0;
            mem_to_reg_e_q <= 1'b0;
            alu_src_e_q    <= 1'b0;
            flag_write_e_q <= 1'b0;
            branch_e_q     <= 1'b0;
            pcs_e_q        <= 1'b0;
            dp_e_q         <= 1'b0;
            alu_ctrl_e_q   <= 4'b0000;
            cond_e_q       <= 4'b0000;
        end else if (FlushE) begin
            reg_write_e_q  <= 1'b0;
            mem_write_e_q  <= 1'b0;
            mem_to_reg_e_q <= 1'b0;
            alu_src_e_q    <= 1'b0;
            flag_write_e_q <= 1'b0;
            branch_e_q     <= 1'b0;
            pcs_e_q        <= 1'b0;
            dp_e_q         <= 1'b0;
            alu_ctrl_e_q   <= 4'b0000;
            cond_e_q       <= 4'b0000;
        end else begin
            reg_write_e_q  <= reg_write_d;
            mem_write_e_q  <= mem_write_d;
            mem_to_reg_e_q <= mem_to_reg_d;
            alu_src_e_q    <= alu_src_d;
            flag_write_e_q <= flag_write_d;
            branch_e_q     <= branch_d;
            pcs_e_q        <= pcs_d;
            dp_e_q         <= dp_d;
            alu_ctrl_e_q   <= alu_ctrl_d;
            cond_e_q       <= INSTR[31:28];
        end
    end

    // E-stage condition check against the live Z flag; only EQ, NE and AL ever execute.
    always_comb begin
        cond_ex_e = 1'b0;
        case (cond_e_q)
            4'b0000: cond_ex_e = FlagZ;
            4'b0001: cond_ex_e = ~FlagZ;
            4'b1110: cond_ex_e = 1'b1;
            default: cond_ex_e = 1'b0;
        endcase
    end

    assign valid_e = cond_ex_e & (reg_write_e_q | mem_write_e_q | pcs_e_q |
                                  branch_e_q | flag_write_e_q | dp_e_q);

    assign ALUSrcE      = alu_src_e_q;
    assign ALUControlE  = alu_ctrl_e_q;
    assign FlagWriteE   = flag_write_e_q & cond_ex_e;
    assign BranchE      = branch_e_q;
    assign BranchTakenE = branch_e_q & cond_ex_e;
    assign MemtoRegE    = mem_to_reg_e_q;
    assign PCSrcE       = pcs_e_q;

    // E->M register; write enables are condition-gated on the way in.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
            pcs_m_q        <= 1'b0;
            valid_m_q      <= 1'b0;
        end else begin
            reg_write_m_q  <= reg_write_e_q & cond_ex_e;
            mem_write_m_q  <= mem_write_e_q & cond_ex_e;
            mem_to_reg_m_q <= mem_to_reg_e_q;
            pcs_m_q        <= pcs_e_q & cond_ex_e;
            valid_m_q      <= valid_e;
        end
    end

    assign RegWriteM = reg_write_m_q;
    assign MemWriteM = mem_write_m_q;
    assign PCSrcM    = pcs_m_q;

    // M->W register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            reg_write_w_q  <= 1'b0;
            mem_to_reg_w_q <= 1'b0;
            pcs_w_q        <= 1'b0;
            valid_w_q      <= 1'b0;
        end else begin
            reg_write_w_q  <= reg_write_m_q;
            mem_to_reg_w_q <= mem_to_reg_m_q;
            pcs_w_q        <= pcs_m_q;
            valid_w_q      <= valid_m_q;
        end
    end

    assign RegWriteW = reg_write_w_q;
    assign MemtoRegW = mem_to_reg_w_q;
    assign PCSrcW    = pcs_w_q;

    assign retired_d = retired_q + CNT_W'(valid_w_q);

    // Retired-instruction counter, wrapping naturally at 2^CNT_W.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign RetiredW = retired_q;

endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller: scoreboard bench for pipe_controller. The expected W-stage
// controls of each instruction are queued when it is evaluated in E and compared
// two edges later when it reaches W; the retire count is tracked alongside.
module tb_pipe_controller;

    localparam int CNT_W = 3;

    localparam logic [31:0] I_ADD  = 32'hE2821005;
    localparam logic [31:0] I_CMP  = 32'hE3520000;
    localparam logic [31:0] I_BEQ  = 32'h0A000002;
    localparam logic [31:0] I_BNE  = 32'h1A000002;
    localparam logic [31:0] I_LDR  = 32'hE5921004;
    localparam logic [31:0] I_STR  = 32'hE5821004;
    localparam logic [31:0] I_BL   = 32'hEB000003;
    localparam logic [31:0] I_BX   = 32'hE12FFF1E;
    localparam logic [31:0] I_NOP  = 32'hEC000000;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [31:0]      INSTR;
    logic             FlagZ;
    logic             FlushE;
    logic [1:0]       RegSrcD, ImmSrcD;
    logic             Sel14, ALUSrcE, FlagWriteE, BranchE, BranchTakenE, MemtoRegE;
    logic [3:0]       ALUControlE;
    logic             RegWriteM, MemWriteM, PCSrcD, PCSrcE, PCSrcM, PCSrcW;
    logic             RegWriteW, MemtoRegW;
    logic [CNT_W-1:0] RetiredW;

    pipe_controller #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .FlagZ(FlagZ), .FlushE(FlushE),
        .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .Sel14(Sel14), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .FlagWriteE(FlagWriteE), .BranchE(BranchE),
        .BranchTakenE(BranchTakenE), .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
        .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .RetiredW(RetiredW)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic rw;
        logic m2r;
        logic pcs;
        logic vld;
    } wexp_t;

    wexp_t            exp_q[$];
    logic [31:0]      e_instr;
    logic             e_bubble;
    logic [CNT_W-1:0] exp_ret;
    logic             pend_ret;
    int               checks = 0;
    int               errors = 0;

    // Expected W-stage controls for an instruction executing in E with flag z.
    function automatic wexp_t model(input logic [31:0] ins, input logic bubble,
                                    input logic z);
        wexp_t r;
        logic  pass;
        r = '0;
        pass = ((ins[31:28] == 4'h0) && z) || ((ins[31:28] == 4'h1) && !z) ||
               (ins[31:28] == 4'hE);
        if (bubble) return r;
        if (ins[27:4] == 24'h12FFF1) begin
            r.pcs = pass;
            r.vld = pass;
        end else if (ins[27:26] == 2'b00) begin
            r.rw  = pass && (ins[24:21] != 4'b1010);
            r.vld = pass;
        end else if (ins[27:26] == 2'b01) begin
            r.rw  = pass && ins[20];
            r.m2r = ins[20];
            r.vld = pass;
        end else if (ins[27:26] == 2'b10) begin
            r.rw  = pass && ins[24];
            r.vld = pass;
        end
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        e_instr  = I_NOP;
        e_bubble = 1'b1;
        exp_ret  = '0;
        pend_ret = 1'b0;
    endtask

    // Present a D-stage instruction; z is the flag seen by the instruction now in E.
    task automatic drive(input logic [31:0] ins, input logic flush, input logic z);
        INSTR  = ins;
        FlushE = flush;
        FlagZ  = z;
        exp_q.push_back(model(e_instr, e_bubble, z));
        e_instr  = ins;
        e_bubble = flush;
        #1;
    endtask

    // Clock edge, then retire-count and W-stage scoreboard comparison.
    task automatic tick();
        wexp_t w;
        @(posedge CLK);
        #1;
        exp_ret = exp_ret + CNT_W'(pend_ret);
        checks++;
        if (RetiredW !== exp_ret) begin
            errors++;
            $display("FAIL retired actual=%0d expected=%0d", RetiredW, exp_ret);
        end
        if (exp_q.size() >= 2) begin
            w = exp_q.pop_front();
            checks++;
            if ({RegWriteW, MemtoRegW, PCSrcW} !== {w.rw, w.m2r, w.pcs}) begin
                errors++;
                $display("FAIL wstage {rw,m2r,pcs} actual=%b expected=%b",
                         {RegWriteW, MemtoRegW, PCSrcW}, {w.rw, w.m2r, w.pcs});
            end
            pend_ret = w.vld;
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic flush, input logic z);
        drive(ins, flush, z);
        tick();
    endtask

    task automatic test_reset();
        RESET  = 1'b0;
        INSTR  = I_NOP;
        FlushE = 1'b0;
        FlagZ  = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({ALUSrcE, ALUControlE, BranchE, MemtoRegE, RegWriteM, MemWriteM, PCSrcE,
             PCSrcM, PCSrcW, RegWriteW, MemtoRegW, RetiredW} !== '0) begin
            errors++;
            $display("FAIL reset_init actual=%h expected=0",
                     {ALUSrcE, ALUControlE, RegWriteW, RetiredW});
        end
        RESET = 1'b1;
    endtask

    task automatic test_reset_mid();
        step(I_ADD, 1'b0, 1'b0);
        step(I_LDR, 1'b0, 1'b0);
        step(I_NOP, 1'b0, 1'b0);
        checks++;
        if (RegWriteW !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre RegWriteW actual=%b expected=1", RegWriteW);
        end
        #2;
        RESET = 1'b0;
        #1;
        checks++;
        if ({ALUSrcE, ALUControlE, FlagWriteE, BranchE, BranchTakenE, MemtoRegE,
             RegWriteM, MemWriteM, PCSrcE, PCSrcM, PCSrcW, RegWriteW, MemtoRegW,
             RetiredW} !== '0) begin
            errors++;
            $display("FAIL reset_mid actual=%h expected=0",
                     {MemtoRegE, RegWriteM, RegWriteW, MemtoRegW, RetiredW});
        end
        #1;
        RESET = 1'b1;
        model_reset();
    endtask

    task automatic test_add();
        logic [CNT_W-1:0] r0;
        r0 = RetiredW;
        drive(I_ADD, 1'b0, 1'b0);
        checks++;
        if ({ImmSrcD, RegSrcD} !== 4'b0000) begin
            errors++;
            $display("FAIL add_dstage actual=%b expected=0000", {ImmSrcD, RegSrcD});
        end
        tick();
        drive(I_NOP, 1'b0, 1'b0);
        checks++;
        if ({ALUControlE, ALUSrcE} !== 5'b01001) begin
            errors++;
            $display("FAIL add_estage actual=%b expected=01001", {ALUControlE, ALUSrcE});
        end
        tick();
        step(I_NOP, 1'b0, 1'b0);
        checks++;
        if (RegWriteW !== 1'b1) begin
            errors++;
            $display("FAIL add_regwritew actual=%b expected=1", RegWriteW);
        end
        step(I_NOP, 1'b0, 1'b0);
        checks++;
        if (RetiredW !== CNT_W'(r0 + 1'b1)) begin
            errors++;
            $display("FAIL add_retired actual=%0d expected=%0d", RetiredW, r0 + 1'b1);
        end
    endtask

    task automatic test_cmp_branch();
        step(I_CMP, 1'b0, 1'b0);
        drive(I_BEQ, 1'b0, 1'b0);
        checks++;
        if (FlagWriteE !== 1'b1) begin
            errors++;
            $display("FAIL cmp_flagwrite actual=%b expected=1", FlagWriteE);
        end
        tick();
        drive(I_NOP, 1'b0, 1'b1);
        checks++;
        if ({BranchE, BranchTakenE} !== 2'b11) begin
            errors++;
            $display("FAIL beq_taken actual=%b expected=11", {BranchE, BranchTakenE});
        end
        tick();
        step(I_CMP, 1'b0, 1'b0);
        step(I_BNE, 1'b0, 1'b0);
        drive(I_NOP, 1'b0, 1'b1);
        checks++;
        if ({BranchE, BranchTakenE} !== 2'b10) begin
            errors++;
            $display("FAIL bne_nottaken actual=%b expected=10", {BranchE, BranchTakenE});
        end
        tick();
        repeat (3) step(I_NOP, 1'b0, 1'b1);
    endtask

    task automatic test_mem();
        step(I_LDR, 1'b0, 1'b0);
        drive(I_STR, 1'b0, 1'b0);
        checks++;
        if (MemtoRegE !== 1'b1) begin
            errors++;
            $display("FAIL ldr_memtorege actual=%b expected=1", MemtoRegE);
        end
        checks++;
        if ({RegSrcD, ImmSrcD} !== 4'b1001) begin
            errors++;
            $display("FAIL str_dstage actual=%b expected=1001", {RegSrcD, ImmSrcD});
        end
        tick();
        step(I_NOP, 1'b0, 1'b0);
        checks++;
        if ({MemtoRegW, RegWriteW, MemWriteM} !== 3'b111) begin
            errors++;
            $display("FAIL ldr_w_str_m actual=%b expected=111",
                     {MemtoRegW, RegWriteW, MemWriteM});
        end
        step(I_NOP, 1'b0, 1'b0);
        checks++;
        if (RegWriteW !== 1'b0) begin
            errors++;
            $display("FAIL str_regwritew actual=%b expected=0", RegWriteW);
        end
    endtask

    task automatic test_bl_bx();
        drive(I_BL, 1'b0, 1'b0);
        checks++;
        if ({Sel14, RegSrcD, ImmSrcD} !== 5'b10110) begin
            errors++;
            $display("FAIL bl_dstage actual=%b expected=10110", {Sel14, RegSrcD, ImmSrcD});
        end
        tick();
        drive(I_BX, 1'b0, 1'b0);
        checks++;
        if (BranchTakenE !== 1'b1) begin
            errors++;
            $display("FAIL bl_taken actual=%b expected=1", BranchTakenE);
        end
        checks++;
        if (PCSrcD !== 1'b1) begin
            errors++;
            $display("FAIL bx_pcsrcd actual=%b expected=1", PCSrcD);
        end
        tick();
        step(I_NOP, 1'b0, 1'b0);
        step(I_NOP, 1'b0, 1'b0);
        checks++;
        if ({PCSrcW, RegWriteW} !== 2'b10) begin
            errors++;
            $display("FAIL bx_wstage actual=%b expected=10", {PCSrcW, RegWriteW});
        end
        step(I_NOP, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        logic [CNT_W-1:0] r0;
        step(I_ADD, 1'b0, 1'b0);
        step(I_NOP, 1'b1, 1'b0);
        repeat (4) step(I_NOP, 1'b0, 1'b0);
        r0 = RetiredW;
        step(I_ADD, 1'b1, 1'b0);
        drive(I_NOP, 1'b0, 1'b0);
        checks++;
        if ({ALUControlE, ALUSrcE, FlagWriteE} !== 6'b0) begin
            errors++;
            $display("FAIL flush_estage actual=%b expected=000000",
                     {ALUControlE, ALUSrcE, FlagWriteE});
        end
        tick();
        repeat (4) step(I_NOP, 1'b0, 1'b0);
        checks++;
        if (RetiredW !== r0) begin
            errors++;
            $display("FAIL flush_retired actual=%0d expected=%0d", RetiredW, r0);
        end
    endtask

    task automatic test_wrap();
        test_reset();
        repeat (7) step(I_ADD, 1'b0, 1'b0);
        repeat (4) step(I_NOP, 1'b0, 1'b0);
        checks++;
        if (RetiredW !== {CNT_W{1'b1}}) begin
            errors++;
            $display("FAIL wrap_full actual=%0d expected=%0d", RetiredW, {CNT_W{1'b1}});
        end
        step(I_ADD, 1'b0, 1'b0);
        repeat (4) step(I_NOP, 1'b0, 1'b0);
        checks++;
        if (RetiredW !== '0) begin
            errors++;
            $display("FAIL wrap_zero actual=%0d expected=0", RetiredW);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tbl [12];
        tbl = '{I_ADD, I_CMP, I_BEQ, I_BNE, I_LDR, I_STR, I_BL, I_BX, I_NOP,
                32'h02821005, 32'hE0421003, 32'h1A3A1007};
        for (int i = 0; i < 60; i++) begin
            step(tbl[$urandom_range(0, 11)], ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)));
        end
        repeat (4) step(I_NOP, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_cmp_branch();
        test_mem();
        test_bl_bx();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
